// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM encoding,
// rst_count saturation limit and default timing parameters.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  localparam logic [7:0] RST_COUNT_MAX = 8'd255;

  localparam int DEF_HOLD_CYC  = 1000000;
  localparam int DEF_STAGE_GAP = 16;
  localparam int DEF_NSTAGE    = 4;
  localparam int DEF_CNT_W     = 20;

endpackage

// File: rtl/rst_sequencer_if.sv
// Request/enable inputs from the long-press detector and the reset/run
// outputs fanned out to the rest of the design.
interface rst_sequencer_if #(
  parameter int NSTAGE = rst_seq_pkg::DEF_NSTAGE
);
  logic              rst_req;
  logic              run_en;
  logic              sys_rst_n;
  logic [NSTAGE-1:0] stage_rst_n;
  logic              busy;
  logic              run;
  logic [7:0]        rst_count;

  modport master (
    output rst_req, run_en,
    input  sys_rst_n, stage_rst_n, busy, run, rst_count
  );

  modport slave (
    input  rst_req, run_en,
    output sys_rst_n, stage_rst_n, busy, run, rst_count
  );
endinterface

// File: rtl/rst_sequencer_sat_counter.sv
// 8-bit saturating event counter; sticks at RST_COUNT_MAX instead of wrapping.
module sat_counter
  import rst_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  output logic [7:0] o_q
);

  logic [7:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= 8'd0;
    end else if (i_inc && (r_q != RST_COUNT_MAX)) begin
      r_q <= r_q + 8'd1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/rst_sequencer.sv
// Holds sys_rst_n low for HOLD_CYC cycles, then releases stage resets one per
// STAGE_GAP cycles; rst_req restarts the sequence from any state.
//   state      | meaning
//   ST_HOLD    | sys_rst_n and all stages low, counting HOLD_CYC
//   ST_RELEASE | sys_rst_n high, releasing stage k every STAGE_GAP
//   ST_RUN     | all released, run follows run_en
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int STAGE_GAP = DEF_STAGE_GAP,
  parameter int NSTAGE    = DEF_NSTAGE,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  rst_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       LAST_K  = 3'(NSTAGE - 1);

  seq_state_e        r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic [2:0]        r_k, w_k_nx;
  logic              r_sys_rst_n, w_sys_nx;
  logic [NSTAGE-1:0] r_stage_rst_n, w_stage_nx;
  logic              r_busy, w_busy_nx;
  logic [NSTAGE-1:0] w_stage_bit;
  logic [7:0]        w_rst_count;

  assign w_stage_bit = NSTAGE'(1) << r_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_HOLD;
      r_cnt         <= '0;
      r_k           <= 3'd0;
      r_sys_rst_n   <= 1'b0;
      r_stage_rst_n <= '0;
      r_busy        <= 1'b1;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_k           <= w_k_nx;
      r_sys_rst_n   <= w_sys_nx;
      r_stage_rst_n <= w_stage_nx;
      r_busy        <= w_busy_nx;
    end
  end

  // rst_req wins over every terminal-count transition, including the last release
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_k_nx     = r_k;
    w_sys_nx   = r_sys_rst_n;
    w_stage_nx = r_stage_rst_n;
    w_busy_nx  = r_busy;
    if (bus.rst_req) begin
      w_state_nx = ST_HOLD;
      w_cnt_nx   = '0;
      w_k_nx     = 3'd0;
      w_sys_nx   = 1'b0;
      w_stage_nx = '0;
      w_busy_nx  = 1'b1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_TC) begin
            w_state_nx = ST_RELEASE;
            w_cnt_nx   = '0;
            w_k_nx     = 3'd0;
            w_sys_nx   = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == GAP_TC) begin
            w_cnt_nx   = '0;
            w_stage_nx = r_stage_rst_n | w_stage_bit;
            w_k_nx     = r_k + 3'd1;
            if (r_k == LAST_K) begin
              w_state_nx = ST_RUN;
              w_busy_nx  = 1'b0;
            end
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
        end
        default: begin
          w_state_nx = ST_HOLD;
          w_cnt_nx   = '0;
          w_k_nx     = 3'd0;
          w_sys_nx   = 1'b0;
          w_stage_nx = '0;
          w_busy_nx  = 1'b1;
        end
      endcase
    end
  end

  sat_counter u_rst_count (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (bus.rst_req),
    .o_q   (w_rst_count)
  );

  assign bus.sys_rst_n   = r_sys_rst_n;
  assign bus.stage_rst_n = r_stage_rst_n;
  assign bus.busy        = r_busy;
  assign bus.run         = bus.run_en & (r_state == ST_RUN);
  assign bus.rst_count   = w_rst_count;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with HOLD_CYC=8, STAGE_GAP=4, NSTAGE=3;
// inputs change and outputs are sampled on the falling edge.
module tb_rst_sequencer;

  localparam int HOLD_CYC  = 8;
  localparam int STAGE_GAP = 4;
  localparam int NSTAGE    = 3;
  localparam int CNT_W     = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_cnt;

  rst_sequencer_if #(.NSTAGE(NSTAGE)) bus ();

  rst_sequencer #(
    .HOLD_CYC  (HOLD_CYC),
    .STAGE_GAP (STAGE_GAP),
    .NSTAGE    (NSTAGE),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_all(input string tag, input logic sys, input logic [2:0] stg,
                         input logic bsy, input logic rn, input logic [7:0] cnt);
    chk({tag, ".sys_rst_n"}, 32'(bus.sys_rst_n), 32'(sys));
    chk({tag, ".stage_rst_n"}, 32'(bus.stage_rst_n), 32'(stg));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    chk({tag, ".run"}, 32'(bus.run), 32'(rn));
    chk({tag, ".rst_count"}, 32'(bus.rst_count), 32'(cnt));
  endtask

  task automatic pulse_req();
    bus.rst_req = 1'b1;
    step(1);
    bus.rst_req = 1'b0;
    exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    exp_cnt     = 0;
    rst         = 1'b1;
    bus.rst_req = 1'b0;
    bus.run_en  = 1'b1;

    // 1: power-up, timing counted in edges after reset release
    #1;
    chk_all("por", 1'b0, 3'b000, 1'b1, 1'b0, 8'd0);
    step(3);
    rst = 1'b0;
    step(7);
    chk_all("pu_e7", 1'b0, 3'b000, 1'b1, 1'b0, 8'd0);
    step(1);
    chk_all("pu_e8", 1'b1, 3'b000, 1'b1, 1'b0, 8'd0);
    step(3);
    chk("pu_e11.stage", 32'(bus.stage_rst_n), 32'b000);
    step(1);
    chk_all("pu_e12", 1'b1, 3'b001, 1'b1, 1'b0, 8'd0);
    step(4);
    chk("pu_e16.stage", 32'(bus.stage_rst_n), 32'b011);
    step(3);
    chk_all("pu_e19", 1'b1, 3'b011, 1'b1, 1'b0, 8'd0);
    step(1);
    chk_all("pu_e20", 1'b1, 3'b111, 1'b0, 1'b1, 8'd0);
    bus.run_en = 1'b0;
    #1;
    chk("run_gate_off", 32'(bus.run), 32'd0);
    bus.run_en = 1'b1;
    #1;
    chk("run_gate_on", 32'(bus.run), 32'd1);

    // 2: request in RUN
    pulse_req();
    chk_all("req_run", 1'b0, 3'b000, 1'b1, 1'b0, 8'(exp_cnt));
    step(7);
    chk("req_run_e7.sys", 32'(bus.sys_rst_n), 32'd0);
    step(1);
    chk("req_run_e8.sys", 32'(bus.sys_rst_n), 32'd1);
    step(4);
    chk("req_run_e12.stage", 32'(bus.stage_rst_n), 32'b001);
    step(4);
    chk("req_run_e16.stage", 32'(bus.stage_rst_n), 32'b011);
    step(4);
    chk_all("req_run_e20", 1'b1, 3'b111, 1'b0, 1'b1, 8'(exp_cnt));

    // 3: request mid-HOLD at cnt=5 restarts the hold count
    pulse_req();
    step(5);
    pulse_req();
    chk_all("hold5_req", 1'b0, 3'b000, 1'b1, 1'b0, 8'(exp_cnt));
    step(3);
    chk("hold5_e3.sys", 32'(bus.sys_rst_n), 32'd0);
    step(4);
    chk("hold5_e7.sys", 32'(bus.sys_rst_n), 32'd0);
    step(1);
    chk("hold5_e8.sys", 32'(bus.sys_rst_n), 32'd1);

    // 4a: request on the terminal HOLD edge
    pulse_req();
    step(7);
    pulse_req();
    chk_all("hold_tc_req", 1'b0, 3'b000, 1'b1, 1'b0, 8'(exp_cnt));
    step(7);
    chk("hold_tc_e7.sys", 32'(bus.sys_rst_n), 32'd0);
    step(1);
    chk("hold_tc_e8.sys", 32'(bus.sys_rst_n), 32'd1);

    // 4b: request on the final stage-release edge
    step(8);
    chk("last_pre.stage", 32'(bus.stage_rst_n), 32'b011);
    step(3);
    pulse_req();
    chk_all("last_rel_req", 1'b0, 3'b000, 1'b1, 1'b0, 8'(exp_cnt));
    step(7);
    chk_all("last_rel_e7", 1'b0, 3'b000, 1'b1, 1'b0, 8'(exp_cnt));
    step(1);
    chk("last_rel_e8.sys", 32'(bus.sys_rst_n), 32'd1);
    step(12);
    chk_all("last_rel_e20", 1'b1, 3'b111, 1'b0, 1'b1, 8'(exp_cnt));

    // 5: saturation of rst_count
    for (int i = 0; i < 300; i++) begin
      pulse_req();
      chk("sat.count", 32'(bus.rst_count), 32'(exp_cnt));
      step(1);
    end
    chk("sat.final", 32'(bus.rst_count), 32'd255);

    // 6: async reset mid-RELEASE, between clock edges
    step(11);
    chk("async_pre.stage", 32'(bus.stage_rst_n), 32'b001);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 3'b000, 1'b1, 1'b0, 8'd0);
    step(2);
    rst = 1'b0;
    step(7);
    chk_all("async_e7", 1'b0, 3'b000, 1'b1, 1'b0, 8'd0);
    step(1);
    chk("async_e8.sys", 32'(bus.sys_rst_n), 32'd1);
    step(12);
    chk_all("async_e20", 1'b1, 3'b111, 1'b0, 1'b1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
